// File: rtl/desconcatenador_numeros_pkg.sv
// desconcatenador_numeros_pkg: shared FSM encoding, ASCII offset and default sizes
//   for the digit splitter and the digit concatenator.
package desconcatenador_numeros_pkg;
   typedef enum logic [2:0] {IDLE, CONV, SKIP, EMIT, WAIT_ACK, FIN} state_t;
   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_DIGITS = 10;
endpackage

// File: rtl/desconcatenador_numeros_bin_a_bcd_seq.sv
// bin_a_bcd_seq: sequential double dabble, one input bit per cycle, WIDTH cycles.
//   clk, reset : clock and synchronous active-high reset
//   load       : clears the BCD registers and captures bin
//   bin        : binary value to convert
//   done       : high during the cycle whose edge performs the final shift
//   bcd        : DIGITS packed BCD nibbles, least significant digit in [3:0]
module bin_a_bcd_seq #(
   parameter int WIDTH = 32,
   parameter int DIGITS = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [WIDTH-1:0]      bin,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);
   localparam int CW = $clog2(WIDTH + 1);
   logic [WIDTH-1:0] sh;
   logic [CW-1:0] cnt;
   logic [4*DIGITS-1:0] adj;
   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      assign adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
   end
   // Combinational so the owner can leave its wait state on the same edge as the last shift.
   assign done = cnt == CW'(1);
   always_ff @(posedge clk) begin
      if (reset) begin
         sh  <= '0;
         bcd <= '0;
         cnt <= '0;
      end else if (load) begin
         sh  <= bin;
         bcd <= '0;
         cnt <= CW'(WIDTH);
      end else if (cnt != '0) begin
         {bcd, sh} <= {adj, sh} << 1;
         cnt <= cnt - CW'(1);
      end
   end
endmodule

// File: rtl/desconcatenador_numeros.sv
// desconcatenador_numeros: splits a binary value into decimal digits, MSD first,
//   leading zeros suppressed, one digit per TX handshake, then a fin pulse.
//   clk, reset : clock and synchronous active-high reset
//   start      : strobe, accepted only when idle; valor sampled then
//   tx_done    : strobe from TX, previous digit consumed
//   dato       : current digit (raw or ASCII), held between strobes
//   num_ready  : strobe, dato valid
//   fin        : strobe after the last digit has been consumed
//   busy       : high from accepted start through the fin cycle
module desconcatenador_numeros
   import desconcatenador_numeros_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIGITS = DEF_DIGITS,
   parameter int ASCII = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] valor,
   input  logic             tx_done,
   output logic [7:0]       dato,
   output logic             num_ready,
   output logic             fin,
   output logic             busy
);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   state_t state, nxt;
   logic [IW-1:0] idx, idx_n;
   logic [4*DIGITS-1:0] bcd;
   logic [3:0] nib;
   logic load, done;
   assign load = state == IDLE && start;
   assign nib  = bcd[{idx, 2'b00} +: 4];
   assign fin  = state == FIN;
   assign busy = state != IDLE;
   bin_a_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_bcd (
      .clk(clk), .reset(reset), .load(load), .bin(valor), .done(done), .bcd(bcd)
   );
   always_comb begin
      nxt   = state;
      idx_n = idx;
      case (state)
         IDLE:     nxt = start ? CONV : IDLE;
         CONV:     if (done) begin
                      nxt   = SKIP;
                      idx_n = IW'(DIGITS - 1);
                   end
         // Stops on the first nonzero nibble, or on digit 0 so a zero value still emits one digit.
         SKIP:     if (nib == 4'd0 && idx != '0) idx_n = idx - IW'(1);
                   else nxt = EMIT;
         EMIT:     nxt = WAIT_ACK;
         WAIT_ACK: if (tx_done) begin
                      nxt   = idx != '0 ? EMIT : FIN;
                      idx_n = idx != '0 ? idx - IW'(1) : idx;
                   end
         FIN:      nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         dato      <= '0;
         num_ready <= 1'b0;
      end else begin
         state     <= nxt;
         idx       <= idx_n;
         num_ready <= state == EMIT;
         if (state == EMIT) dato <= ASCII != 0 ? {4'h0, nib} + ASCII_ZERO : {4'h0, nib};
      end
   end
endmodule

// File: tb/tb_desconcatenador_numeros.sv
// tb_desconcatenador_numeros: randomized and directed check of the digit splitter
//   against a decimal-arithmetic reference model.
module tb_desconcatenador_numeros;
   logic clk = 0, reset = 1, start = 0, resp_tx = 0, man_tx = 0;
   logic [31:0] valor = 0;
   logic tx_done;
   logic [7:0] dato;
   logic num_ready, fin, busy;
   assign tx_done = resp_tx | man_tx;

   desconcatenador_numeros dut (
      .clk(clk), .reset(reset), .start(start), .valor(valor), .tx_done(tx_done),
      .dato(dato), .num_ready(num_ready), .fin(fin), .busy(busy)
   );

   always #5 clk = ~clk;

   int cmp = 0, bad = 0, fin_cnt = 0, ack_delay = -1;
   bit ack_en = 1;
   int exp_q[$];
   int got[$];
   bit exp_busy = 0, pending_ack = 0, fin_due = 0, rst_prev = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      cmp++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void push_digits(input longint v);
      int t[$];
      if (v == 0) t.push_back(0);
      while (v > 0) begin
         t.push_front(int'(v % 10));
         v = v / 10;
      end
      foreach (t[i]) exp_q.push_back(t[i]);
   endfunction

   function automatic longint rebuild();
      longint r = 0;
      foreach (got[i]) r = r * 10 + got[i];
      return r;
   endfunction

   // Reference model and per-cycle compare, sampled on the falling edge.
   always @(negedge clk) begin
      bit b, fin_now;
      if (reset) begin
         exp_q.delete();
         exp_busy = 0;
         pending_ack = 0;
         fin_due = 0;
         rst_prev = 1;
      end else begin
         if (rst_prev) begin
            chk("reset_dato", dato, 0);
            chk("reset_num_ready", num_ready, 0);
            rst_prev = 0;
         end
         b = exp_busy;
         fin_now = fin_due;
         fin_due = 0;
         chk("busy", busy, b);
         chk("fin", fin, fin_now);
         if (fin) fin_cnt++;
         if (fin_now) exp_busy = 0;
         if (num_ready) begin
            chk("digit_before_ack", pending_ack, 0);
            chk("digit_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("digit", dato, exp_q.pop_front());
            got.push_back(int'(dato));
            pending_ack = 1;
         end
         if (pending_ack && tx_done) begin
            pending_ack = 0;
            if (exp_q.size() == 0) fin_due = 1;
         end
         if (start && !b) begin
            exp_busy = 1;
            push_digits(longint'(valor));
         end
      end
   end

   // TX responder: acknowledges each digit after 0..3 cycles (0 = same cycle as num_ready).
   always begin
      int d;
      @(posedge clk);
      #1;
      if (num_ready && ack_en) begin
         d = ack_delay < 0 ? int'($urandom_range(0, 3)) : ack_delay;
         repeat (d) begin
            @(posedge clk);
            #1;
         end
         resp_tx = 1;
         @(posedge clk);
         #1;
         resp_tx = 0;
      end
   end

   task automatic go(input logic [31:0] v);
      @(posedge clk);
      #1;
      valor = v;
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
   endtask

   task automatic wait_fin(input int f0);
      int n = 0;
      while (fin_cnt == f0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      chk("op_finished", fin_cnt > f0, 1);
      repeat (3) @(posedge clk);
   endtask

   task automatic run(input logic [31:0] v);
      int f0 = fin_cnt;
      got.delete();
      go(v);
      wait_fin(f0);
   endtask

   initial begin
      int f0, lat, n;
      logic [31:0] v;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("rst_dato", dato, 0);
      chk("rst_num_ready", num_ready, 0);
      chk("rst_fin", fin, 0);
      chk("rst_busy", busy, 0);

      ack_delay = 3;
      f0 = fin_cnt;
      run(32'd981498149);
      chk("seq_value", rebuild(), 981498149);
      chk("seq_count", got.size(), 9);
      chk("seq_fins", fin_cnt - f0, 1);

      run(32'd0);
      chk("zero_count", got.size(), 1);
      chk("zero_value", rebuild(), 0);

      ack_delay = -1;
      f0 = fin_cnt;
      got.delete();
      go(32'hFFFF_FFFF);
      lat = 0;
      while (lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
         if (num_ready) break;
      end
      chk("max_latency", lat, 34);
      wait_fin(f0);
      chk("max_value", rebuild(), 64'd4294967295);
      chk("max_count", got.size(), 10);

      f0 = fin_cnt;
      got.delete();
      go(32'd111775344);
      repeat (5) @(posedge clk);
      go(32'd7);
      wait_fin(f0);
      chk("ignored_start_value", rebuild(), 111775344);
      chk("ignored_start_count", got.size(), 9);
      repeat (20) @(posedge clk);
      chk("ignored_start_fins", fin_cnt - f0, 1);

      ack_en = 0;
      f0 = fin_cnt;
      got.delete();
      go(32'd8675309);
      n = 0;
      while (!num_ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("hold_first_digit", num_ready, 1);
      n = 0;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (num_ready) n++;
      end
      chk("hold_no_strobe", n, 0);
      chk("hold_busy", busy, 1);
      man_tx = 1;
      @(posedge clk);
      #1 man_tx = 0;
      ack_en = 1;
      wait_fin(f0);
      chk("hold_value", rebuild(), 8675309);

      got.delete();
      repeat (4) begin
         @(posedge clk);
         #1 man_tx = 1;
         @(posedge clk);
         #1 man_tx = 0;
      end
      repeat (10) @(posedge clk);
      chk("stray_tx_digits", got.size(), 0);

      f0 = fin_cnt;
      got.delete();
      go(32'd123456789);
      n = 0;
      while (got.size() < 3 && n < 500) begin
         @(posedge clk);
         n++;
      end
      chk("reset_mid_reached", got.size(), 3);
      #1 reset = 1;
      @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("mid_rst_dato", dato, 0);
      chk("mid_rst_fin", fin, 0);
      chk("mid_rst_busy", busy, 0);
      repeat (10) @(posedge clk);
      chk("mid_rst_no_fin", fin_cnt - f0, 0);
      f0 = fin_cnt;
      run(32'd5);
      chk("after_rst_count", got.size(), 1);
      chk("after_rst_value", rebuild(), 5);
      chk("after_rst_fins", fin_cnt - f0, 1);

      repeat (20) begin
         v = $urandom >> $urandom_range(0, 31);
         run(v);
         chk("rand_value", rebuild(), longint'(v));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
endmodule
